// File: rtl/ai_paddle_controller_if.sv
// Prediction bus from the collision predictor to the AI paddle controller.
interface ai_paddle_controller_if;
    logic       predicted_valid;
    logic [9:0] predicted_y;
    logic       ball_move_up;

    // Collision predictor side
    modport master (
        output predicted_valid,
        output predicted_y,
        output ball_move_up
    );

    // Paddle controller side
    modport slave (
        input predicted_valid,
        input predicted_y,
        input ball_move_up
    );
endinterface

// File: rtl/ai_paddle_controller.sv
// Computer-player left paddle: latches a clamped, direction-biased target on
// each new prediction and slews toward it at a bounded per-frame speed,
// returning to screen centre when no prediction is valid.
module ai_paddle_controller #(
    parameter int unsigned VVIDEO_ON     = 480,
    parameter int unsigned PADDLE_HEIGHT = 64,
    parameter int unsigned PADDLE_SPEED  = 4,
    parameter int unsigned AIM_OFFSET    = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_enable,
    input  logic                    i_vsync_start,
    ai_paddle_controller_if.slave   pred,
    output logic [9:0]              o_paddle_y,
    output logic                    o_paddle_moving,
    output logic                    o_at_target
);

    localparam int unsigned Y_W = 10;
    localparam logic [Y_W-1:0]    CENTRE = Y_W'((VVIDEO_ON - PADDLE_HEIGHT) / 2);
    localparam logic [Y_W-1:0]    MAX_Y  = Y_W'(VVIDEO_ON - PADDLE_HEIGHT);
    localparam logic [Y_W-1:0]    SPEED  = Y_W'(PADDLE_SPEED);
    localparam logic signed [Y_W:0] HALF_S = (Y_W+1)'(PADDLE_HEIGHT / 2);
    localparam logic signed [Y_W:0] AIM_S  = (Y_W+1)'(AIM_OFFSET);
    localparam logic signed [Y_W:0] MAX_S  = (Y_W+1)'(VVIDEO_ON - PADDLE_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [Y_W-1:0] target, target_n;
    logic [Y_W-1:0] paddle_y, paddle_n;
    logic           prev_valid;
    logic           moving, moving_n;

    logic                 rise;
    logic signed [Y_W:0]  raw;
    logic [Y_W-1:0]       clamped;
    logic [Y_W-1:0]       diff_abs;
    logic [Y_W-1:0]       step;
    logic                 go_up;

    assign rise = pred.predicted_valid & ~prev_valid;

    // Aim point: centre paddle on predicted row, biased along ball travel, clamped on screen
    always_comb begin
        raw     = $signed({1'b0, pred.predicted_y}) - HALF_S
                  + (pred.ball_move_up ? -AIM_S : AIM_S);
        clamped = raw[Y_W-1:0];
        if (raw[Y_W]) begin
            clamped = '0;
        end else if (raw > MAX_S) begin
            clamped = MAX_Y;
        end
    end

    // Bounded step toward the currently registered target
    always_comb begin
        go_up    = 1'b0;
        diff_abs = target - paddle_y;
        if (paddle_y > target) begin
            go_up    = 1'b1;
            diff_abs = paddle_y - target;
        end
        step = (diff_abs > SPEED) ? SPEED : diff_abs;
    end

    // State register and datapath registers
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= ST_IDLE;
            target     <= CENTRE;
            paddle_y   <= CENTRE;
            prev_valid <= 1'b0;
            moving     <= 1'b0;
        end else begin
            state      <= state_n;
            target     <= target_n;
            paddle_y   <= paddle_n;
            prev_valid <= pred.predicted_valid;
            moving     <= moving_n;
        end
    end

    // Next-state, target capture and per-frame movement
    always_comb begin
        state_n  = state;
        target_n = target;
        paddle_n = paddle_y;
        moving_n = moving;
        if (!i_enable) begin
            state_n  = ST_IDLE;
            moving_n = 1'b0;
        end else begin
            if (i_vsync_start) begin
                paddle_n = go_up ? (paddle_y - step) : (paddle_y + step);
                moving_n = (step != '0);
            end
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        target_n = clamped;
                        state_n  = ST_TRACK;
                    end else begin
                        target_n = CENTRE;
                        if (paddle_y != CENTRE) begin
                            state_n = ST_RETURN;
                        end
                    end
                end
                ST_TRACK: begin
                    if (!pred.predicted_valid) begin
                        target_n = CENTRE;
                        state_n  = ST_RETURN;
                    end else if (paddle_y == target) begin
                        state_n = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!pred.predicted_valid) begin
                        target_n = CENTRE;
                        state_n  = ST_RETURN;
                    end
                end
                ST_RETURN: begin
                    if (rise) begin
                        target_n = clamped;
                        state_n  = ST_TRACK;
                    end else if (paddle_y == CENTRE) begin
                        state_n = ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign o_paddle_y      = paddle_y;
    assign o_paddle_moving = moving;
    assign o_at_target     = (paddle_y == target);

endmodule

// File: tb/tb_ai_paddle_controller.sv
// Directed bench for the AI paddle controller.
module tb_ai_paddle_controller;

    logic       i_clock;
    logic       i_reset_n;
    logic       i_enable;
    logic       i_vsync_start;
    logic [9:0] o_paddle_y;
    logic       o_paddle_moving;
    logic       o_at_target;

    int checks   = 0;
    int failures = 0;

    ai_paddle_controller_if pred_if ();

    ai_paddle_controller dut (
        .i_clock         (i_clock),
        .i_reset_n       (i_reset_n),
        .i_enable        (i_enable),
        .i_vsync_start   (i_vsync_start),
        .pred            (pred_if.slave),
        .o_paddle_y      (o_paddle_y),
        .o_paddle_moving (o_paddle_moving),
        .o_at_target     (o_at_target)
    );

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clock);
    endtask

    task automatic vsyncs(input int n);
        for (int i = 0; i < n; i++) begin
            i_vsync_start = 1'b1;
            @(negedge i_clock);
            i_vsync_start = 1'b0;
        end
    endtask

    task automatic predict(input logic v, input logic [9:0] y, input logic up);
        pred_if.predicted_valid = v;
        pred_if.predicted_y     = y;
        pred_if.ball_move_up    = up;
    endtask

    initial begin
        i_reset_n     = 1'b0;
        i_enable      = 1'b1;
        i_vsync_start = 1'b0;
        predict(1'b0, 10'd0, 1'b0);
        repeat (3) tick();
        check("reset_y", 32'(o_paddle_y), 32'd208);
        check("reset_moving", 32'(o_paddle_moving), 32'd0);
        check("reset_at_target", 32'(o_at_target), 32'd1);
        i_reset_n = 1'b1;
        tick();

        // Track down: 400 -> target 376
        predict(1'b1, 10'd400, 1'b0);
        tick();
        check("track_at_target_low", 32'(o_at_target), 32'd0);
        vsyncs(41);
        check("track_41", 32'(o_paddle_y), 32'd372);
        check("track_moving", 32'(o_paddle_moving), 32'd1);
        vsyncs(1);
        check("track_42", 32'(o_paddle_y), 32'd376);
        check("track_at_target", 32'(o_at_target), 32'd1);
        tick();
        predict(1'b1, 10'd100, 1'b0);
        vsyncs(1);
        check("hold_y", 32'(o_paddle_y), 32'd376);
        check("hold_moving", 32'(o_paddle_moving), 32'd0);
        check("hold_ignores_y", 32'(o_at_target), 32'd1);

        // Return to centre
        predict(1'b0, 10'd100, 1'b0);
        tick();
        check("return_at_target_low", 32'(o_at_target), 32'd0);
        vsyncs(42);
        check("return_y", 32'(o_paddle_y), 32'd208);
        check("return_at_target", 32'(o_at_target), 32'd1);
        check("return_moving", 32'(o_paddle_moving), 32'd1);
        tick();
        vsyncs(1);
        check("idle_still", 32'(o_paddle_y), 32'd208);
        check("idle_moving", 32'(o_paddle_moving), 32'd0);

        // Clamp low: 10 up -> raw -30 -> 0
        predict(1'b1, 10'd10, 1'b1);
        tick();
        vsyncs(52);
        check("clamp_low_y", 32'(o_paddle_y), 32'd0);
        check("clamp_low_at_target", 32'(o_at_target), 32'd1);
        vsyncs(1);
        check("clamp_low_stay", 32'(o_paddle_y), 32'd0);
        check("clamp_low_moving", 32'(o_paddle_moving), 32'd0);

        // Clamp high: 470 down -> raw 446 -> 416, worst-case 104 frames
        predict(1'b0, 10'd10, 1'b1);
        tick();
        predict(1'b1, 10'd470, 1'b0);
        tick();
        vsyncs(103);
        check("clamp_high_103", 32'(o_paddle_y), 32'd412);
        vsyncs(1);
        check("clamp_high_y", 32'(o_paddle_y), 32'd416);
        vsyncs(1);
        check("clamp_high_stay", 32'(o_paddle_y), 32'd416);

        // Back to centre, then partial step: 226 up -> target 186
        predict(1'b0, 10'd470, 1'b0);
        tick();
        vsyncs(52);
        check("return2_y", 32'(o_paddle_y), 32'd208);
        tick();
        predict(1'b1, 10'd226, 1'b1);
        tick();
        vsyncs(5);
        check("partial_5", 32'(o_paddle_y), 32'd188);
        vsyncs(1);
        check("partial_final", 32'(o_paddle_y), 32'd186);
        check("partial_at_target", 32'(o_at_target), 32'd1);
        vsyncs(1);
        check("partial_no_overshoot", 32'(o_paddle_y), 32'd186);
        check("partial_moving", 32'(o_paddle_moving), 32'd0);

        // Valid edge coincident with vsync uses the old target
        predict(1'b0, 10'd226, 1'b1);
        tick();
        vsyncs(1);
        check("edge_pre", 32'(o_paddle_y), 32'd190);
        predict(1'b1, 10'd10, 1'b1);
        vsyncs(1);
        check("edge_old_target", 32'(o_paddle_y), 32'd194);
        vsyncs(1);
        check("edge_new_target", 32'(o_paddle_y), 32'd190);
        vsyncs(1);
        check("pre_disable", 32'(o_paddle_y), 32'd186);

        // Enable gating
        i_enable = 1'b0;
        vsyncs(10);
        check("disabled_y", 32'(o_paddle_y), 32'd186);
        check("disabled_moving", 32'(o_paddle_moving), 32'd0);
        i_enable = 1'b1;
        tick();
        vsyncs(5);
        check("reenable_5", 32'(o_paddle_y), 32'd206);
        vsyncs(1);
        check("reenable_centre", 32'(o_paddle_y), 32'd208);
        check("reenable_at_target", 32'(o_at_target), 32'd1);

        // Asynchronous reset mid-move
        predict(1'b0, 10'd10, 1'b1);
        tick();
        predict(1'b1, 10'd400, 1'b0);
        tick();
        vsyncs(3);
        check("pre_reset_y", 32'(o_paddle_y), 32'd220);
        check("pre_reset_moving", 32'(o_paddle_moving), 32'd1);
        #2;
        i_vsync_start = 1'b1;
        i_reset_n     = 1'b0;
        #1;
        check("async_reset_y", 32'(o_paddle_y), 32'd208);
        check("async_reset_moving", 32'(o_paddle_moving), 32'd0);
        check("async_reset_at_target", 32'(o_at_target), 32'd1);
        tick();
        i_vsync_start = 1'b0;
        predict(1'b0, 10'd400, 1'b0);
        i_reset_n = 1'b1;
        tick();
        vsyncs(1);
        check("post_reset_y", 32'(o_paddle_y), 32'd208);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ai_paddle_controller.md
# ai_paddle_controller

Computer-player paddle driver for the left paddle. Consumes the predicted wall-hit row from the collision predictor (`o_predicted_valid`, `o_predicted_y`, `o_ball_move_up`), converts it into a clamped paddle target, and slews the paddle toward it at a bounded per-frame speed. When no prediction is valid, it returns the paddle to screen centre. Its output feeds the paddle renderer and the ball collision logic in place of the player-input paddle position.

## Interface

- `VVIDEO_ON`, 480 — visible lines; the paddle must satisfy `top + PADDLE_HEIGHT <= VVIDEO_ON`.
- `PADDLE_HEIGHT`, 64 — paddle height in lines; must be even.
- `PADDLE_SPEED`, 4 — maximum movement per frame in lines; must be ≥1.
- `AIM_OFFSET`, 8 — bias in lines applied toward the ball's travel direction.

Ports:

- `i_clock` in 1 — system/pixel clock.
- `i_reset_n` in 1 — reset is asynchronous and active-low.
- `i_enable` in 1 — AI mode enable; when low, the paddle is frozen and the FSM is held in IDLE.
- `i_vsync_start` in 1 — one-cycle pulse per frame; the only cycle in which the paddle moves.
- `i_predicted_valid` in 1 — from the collision predictor.
- `i_predicted_y` in 10 — predicted ball row at the left wall.
- `i_ball_move_up` in 1 — ball travelling upward at the final bounce.
- `o_paddle_y` out 10 — paddle top row.
- `o_paddle_moving` out 1 — high during a frame in which `o_paddle_y` changed on the last vsync.
- `o_at_target` out 1 — high when `o_paddle_y == target`.

## Operation

- Registers:
  - `state` (2b).
  - `target` (10b).
  - `paddle_y` (10b).
  - `prev_valid` (1b).
  - `moving` (1b).
- `CENTRE` is `(VVIDEO_ON - PADDLE_HEIGHT)/2`, which is 208 by default.
- Target computation uses an 11-bit signed intermediate:
  - `raw = i_predicted_y - PADDLE_HEIGHT/2 + (i_ball_move_up ? -AIM_OFFSET : +AIM_OFFSET)`.
  - Clamp `raw` to `[0, VVIDEO_ON - PADDLE_HEIGHT]`.
  - Negative values clamp to 0; values above 416 clamp to 416.
- FSM states:
  - IDLE (reset)
  - TRACK
  - HOLD
  - RETURN
- FSM transitions:
  - IDLE: on rising edge of `i_predicted_valid` (`valid & ~prev_valid`), load `target` with the clamped value → TRACK. Otherwise `target = CENTRE`. If `paddle_y != CENTRE`, → RETURN.
  - TRACK: on `paddle_y == target`, → HOLD. On `~i_predicted_valid`, → RETURN with `target = CENTRE`.
  - HOLD: on `~i_predicted_valid`, → RETURN with `target = CENTRE`.
  - RETURN: on `paddle_y == CENTRE`, → IDLE. On a new valid rising edge, load target → TRACK.
- The target is captured only on the rising edge of valid. Changes to `i_predicted_y` while valid stays high are ignored.
- Movement occurs only on an `i_vsync_start` cycle with `i_enable` high:
  - `diff = target - paddle_y`.
  - `step = min(|diff|, PADDLE_SPEED)`.
  - Add or subtract `step` toward the target; the paddle never overshoots.
  - In IDLE and HOLD, `diff` is 0 by construction, so the paddle does not move.
- `moving` is updated every vsync: set to `step != 0`.
- `i_enable` low:
  - `state` → IDLE.
  - `paddle_y` and `target` hold.
  - `moving` is cleared.
  - After re-enable, the paddle returns to CENTRE through IDLE → RETURN.

## Timing

- Reset values:
  - `o_paddle_y = CENTRE` (208).
  - `o_paddle_moving = 0`.
  - `o_at_target = 1`.
  - `state = IDLE`.
  - `target = CENTRE`.
  - `prev_valid = 0`.
- Reset is asynchronous mid-operation: all registers return to reset values immediately, with no completion of a pending move.
- Target latch latency: `target` holds the new value 1 cycle after the valid rising edge.
- Simultaneous valid rising edge and `i_vsync_start`: the position update uses the pre-edge `target` register. The new target takes effect from the next vsync.
- `o_at_target` is combinational from registers and valid in the same cycle as `paddle_y` or `target` updates.
- No combinational path exists from inputs to `o_paddle_y`.
- Worst-case frames to reach a target: `ceil(416/PADDLE_SPEED)` = 104.

## Test plan

- **Reset:** assert `i_reset_n = 0` mid-frame → `o_paddle_y = 208`, `o_paddle_moving = 0`, `o_at_target = 1` asynchronously.
- **Track down:** valid rises with `i_predicted_y = 400`, `move_up = 0` → `target = 376`. After 42 vsyncs `o_paddle_y = 376` (41×4 + 4). HOLD is reached, `o_at_target = 1`, and no further motion occurs.
- **Clamp:**
  - `i_predicted_y = 10`, `move_up = 1` → raw = −30, target 0.
  - `i_predicted_y = 470`, `move_up = 0` → raw = 446, target 416.
- **Partial step:** `i_predicted_y = 226`, `move_up = 1` → `target = 186`. Vsyncs move the paddle 208 → 204 → … → 188 → 186, with the final step equal to 2 and no overshoot.
- **Return, and edge with vsync:**
  - Drop valid in HOLD at 376 → RETURN, then 42 vsyncs back to 208 and IDLE.
  - A valid rising edge coincident with vsync → that frame moves toward the old target.
- **Enable gating:** `i_enable = 0` during TRACK across 10 vsyncs → `o_paddle_y` unchanged and `o_paddle_moving = 0`. Re-enable → the paddle returns to 208.
